// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32 load/store FUNC3
// encodings, FSM state type and byte-enable width.
package dmem_pkg;

  // RV32 load/store size/sign encodings (loads and stores share 000..010)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned BE_WIDTH = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAccess  = 2'd1,
    StRespond = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
//   i_func3      access size/sign (RV32 encoding)
//   i_addr_lo    byte offset within the word
//   i_mem_read   load request
//   i_mem_write  store request
//   i_wdata      right-aligned store data
//   i_rword      raw RAM word for loads
//   o_be         store byte enables
//   o_wdata      store data replicated onto every lane
//   o_rdata      lane-selected, extended load result
//   o_fault      misaligned or illegal request
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]          i_func3,
  input  logic [1:0]          i_addr_lo,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [31:0]         i_wdata,
  input  logic [31:0]         i_rword,
  output logic [BE_WIDTH-1:0] o_be,
  output logic [31:0]         o_wdata,
  output logic [31:0]         o_rdata,
  output logic                o_fault
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_rword >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    o_rdata = i_rword;
    unique case (i_func3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0, w_half};
      default: o_rdata = i_rword;
    endcase
  end

  // Replicating the data lets the enables alone pick the destination lane
  always_comb begin
    o_be    = '0;
    o_wdata = i_wdata;
    unique case (i_func3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_W:    o_be = 4'b1111;
      default: o_be = '0;
    endcase
  end

  always_comb begin
    o_fault = 1'b0;
    unique case (i_func3)
      F3_B:    o_fault = 1'b0;
      F3_H:    o_fault = i_addr_lo[0];
      F3_W:    o_fault = (i_addr_lo != 2'b00);
      F3_BU:   o_fault = i_mem_write;
      F3_HU:   o_fault = i_mem_write | i_addr_lo[0];
      default: o_fault = 1'b1;
    endcase
    if (i_mem_read && i_mem_write) o_fault = 1'b1;
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder serving MEM-stage loads and stores.
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_address     byte address (wraps modulo RAM size)
//   i_write_data  right-aligned store data
//   i_mem_read    load request
//   i_mem_write   store request
//   i_func3       access size/sign
//   o_read_data   extended load result, held until next load or fault
//   o_busy        pipeline stall request
//   o_error       one-cycle fault flag in the RESPOND cycle
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_func3,
  output logic [31:0] o_read_data,
  output logic        o_busy,
  output logic        o_error
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_widx;
  logic [1:0]            r_addr_lo;
  logic [31:0]           r_wdata;
  logic [2:0]            r_func3;
  logic                  r_is_write;
  logic [31:0]           r_read_data;
  logic                  r_error;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_idle;
  logic                  w_active;
  logic                  w_last;
  logic [2:0]            w_func3;
  logic [1:0]            w_addr_lo;
  logic                  w_rd;
  logic                  w_wr;
  logic [BE_WIDTH-1:0]   w_be;
  logic [31:0]           w_wdata_rep;
  logic [31:0]           w_load;
  logic                  w_fault;
  logic                  w_unused_addr;

  assign w_unused_addr = ^{i_address[31:ADDR_WIDTH+2]};

  // Both strobes high is still activity: it must stall one cycle and fault
  assign w_active = i_mem_read | i_mem_write;
  assign w_idle   = (r_state == StIdle);
  assign w_last   = (r_state == StAccess) && (r_cnt == '0);

  // Live inputs feed the fault check in IDLE; captured copies drive the access
  assign w_func3   = w_idle ? i_func3 : r_func3;
  assign w_addr_lo = w_idle ? i_address[1:0] : r_addr_lo;
  assign w_rd      = w_idle ? i_mem_read : ~r_is_write;
  assign w_wr      = w_idle ? i_mem_write : r_is_write;

  dmem_lane_align u_lane_align (
    .i_func3     (w_func3),
    .i_addr_lo   (w_addr_lo),
    .i_mem_read  (w_rd),
    .i_mem_write (w_wr),
    .i_wdata     (r_wdata),
    .i_rword     (r_mem[r_widx]),
    .o_be        (w_be),
    .o_wdata     (w_wdata_rep),
    .o_rdata     (w_load),
    .o_fault     (w_fault)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_error     <= 1'b0;
      r_widx      <= '0;
      r_addr_lo   <= '0;
      r_wdata     <= '0;
      r_func3     <= '0;
      r_is_write  <= 1'b0;
    end else begin
      r_error <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_active) begin
            if (w_fault) begin
              r_state     <= StRespond;
              r_error     <= 1'b1;
              r_read_data <= '0;
            end else begin
              r_state    <= StAccess;
              r_cnt      <= CNT_W'(LATENCY - 1);
              r_widx     <= i_address[ADDR_WIDTH+1:2];
              r_addr_lo  <= i_address[1:0];
              r_wdata    <= i_write_data;
              r_func3    <= i_func3;
              r_is_write <= i_mem_write;
            end
          end
        end
        StAccess: begin
          if (r_cnt == '0) begin
            r_state <= StRespond;
            if (!r_is_write) r_read_data <= w_load;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StRespond: r_state <= StIdle;
        default:   r_state <= StIdle;
      endcase
    end
  end

  // RAM is not reset; a reset in the final access cycle drops the store
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_last && r_is_write) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (w_be[i]) r_mem[r_widx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  assign o_busy      = (w_idle && w_active) || (r_state == StAccess);
  assign o_read_data = r_read_data;
  assign o_error     = r_error;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] read_data;
  logic        busy;
  logic        error;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH (10),
    .LATENCY    (LAT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_address    (address),
    .i_write_data (write_data),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_func3      (func3),
    .o_read_data  (read_data),
    .o_busy       (busy),
    .o_error      (error)
  );

  typedef struct {
    int          busy_n;
    logic        err;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
  } req_t;

  exp_t        sb[$];
  logic [31:0] mem_m [int];
  logic [31:0] last_rd;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  function automatic logic model_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a);
    if (rd && wr) return 1'b1;
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return wr;
      3'b101:  return wr || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mem_m[widx(a)];
    b = w[8*a[1:0] +: 8];
    h = w[16*a[1] +: 16];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'h0;
    case (f3)
      3'b000:  w[8*a[1:0] +: 8] = d[7:0];
      3'b001:  w[16*a[1] +: 16] = d[15:0];
      default: w = d;
    endcase
    mem_m[widx(a)] = w;
  endtask

  // Drives one request, pushes the expected response, observes the DUT's response
  task automatic run_req(input req_t r, output int busy_n, output logic err,
                         output logic [31:0] rdata);
    exp_t e;
    @(posedge clk); #1;
    mem_read   = r.rd;
    mem_write  = r.wr;
    func3      = r.f3;
    address    = r.addr;
    write_data = r.wd;
    if (model_fault(r.rd, r.wr, r.f3, r.addr)) begin
      e = '{busy_n: 1, err: 1'b1, data: 32'h0};
      last_rd = 32'h0;
    end else if (r.wr) begin
      e = '{busy_n: LAT + 1, err: 1'b0, data: last_rd};
      model_store(r.f3, r.addr, r.wd);
    end else begin
      last_rd = model_load(r.f3, r.addr);
      e = '{busy_n: LAT + 1, err: 1'b0, data: last_rd};
    end
    sb.push_back(e);
    busy_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
      busy_n++;
    end
    err   = error;
    rdata = read_data;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b0; address = '0; write_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    n_tests++;
    if ({busy, error, read_data} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset: busy=%b err=%b data=%h, want 0 0 00000000", busy, error, read_data);
    end
  endtask

  task automatic test_table(input string name, input req_t tbl[]);
    int          bn;
    logic        er;
    logic [31:0] rd;
    exp_t        e;
    foreach (tbl[i]) begin
      run_req(tbl[i], bn, er, rd);
      e = sb.pop_front();
      n_tests++;
      if (bn !== e.busy_n || er !== e.err || rd !== e.data) begin
        n_fail++;
        $display("FAIL %s[%0d]: busy=%0d err=%b data=%h, want busy=%0d err=%b data=%h",
                 name, i, bn, er, rd, e.busy_n, e.err, e.data);
      end
    end
  endtask

  task automatic test_word();
    req_t t[] = '{'{0, 1, F3_W, 32'h10, 32'hDEADBEEF}, '{1, 0, F3_W, 32'h10, 32'h0}};
    test_table("word", t);
    n_tests++;
    if (read_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_kat: data=%h, want deadbeef", read_data);
    end
  endtask

  task automatic test_extend();
    req_t        st[] = '{'{0, 1, F3_W, 32'h20, 32'h8001F07F}};
    req_t        ld[5];
    logic [31:0] kat[5] = '{32'h0000007F, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001,
                            32'h00008001};
    ld = '{'{1, 0, F3_B, 32'h20, 0}, '{1, 0, F3_B, 32'h21, 0}, '{1, 0, F3_BU, 32'h21, 0},
           '{1, 0, F3_H, 32'h22, 0}, '{1, 0, F3_HU, 32'h22, 0}};
    test_table("ext_init", st);
    for (int i = 0; i < 5; i++) begin
      req_t one[] = '{ld[i]};
      test_table("extend", one);
      n_tests++;
      if (read_data !== kat[i]) begin
        n_fail++;
        $display("FAIL extend_kat[%0d]: data=%h, want %h", i, read_data, kat[i]);
      end
    end
  endtask

  task automatic test_partial();
    req_t t[] = '{'{0, 1, F3_W, 32'h30, 32'h11223344}, '{0, 1, F3_B, 32'h32, 32'h000000AA},
                  '{0, 1, F3_H, 32'h30, 32'h0000BEEF}, '{1, 0, F3_W, 32'h30, 32'h0}};
    test_table("partial", t);
    n_tests++;
    if (read_data !== 32'h11AABEEF) begin
      n_fail++;
      $display("FAIL partial_kat: data=%h, want 11aabeef", read_data);
    end
  endtask

  task automatic test_faults();
    req_t t[] = '{'{1, 0, F3_W, 32'h11, 32'h0}, '{1, 0, F3_W, 32'h10, 32'h0},
                  '{0, 1, F3_H, 32'h21, 32'h5555}, '{1, 0, F3_W, 32'h20, 32'h0},
                  '{1, 0, 3'b011, 32'h20, 32'h0}, '{1, 1, F3_W, 32'h30, 32'h0BADF00D},
                  '{1, 0, F3_W, 32'h30, 32'h0}, '{0, 1, F3_BU, 32'h30, 32'h77}};
    test_table("faults", t);
  endtask

  task automatic test_reset_mid_store();
    req_t clr[] = '{'{0, 1, F3_W, 32'h40, 32'h0}};
    req_t chk[] = '{'{1, 0, F3_W, 32'h40, 32'h0}};
    test_table("rst_clr", clr);
    @(posedge clk); #1;
    mem_write = 1'b1; func3 = F3_W; address = 32'h40; write_data = 32'h12345678;
    @(posedge clk); #1;   // ACCESS, counter 1
    @(posedge clk); #1;   // ACCESS, counter 0: commit would happen at next edge
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_write = 1'b0;
    last_rd = 32'h0;
    @(negedge clk);
    n_tests++;
    if ({busy, error, read_data, dut.r_state} !== {1'b0, 1'b0, 32'h0, StIdle}) begin
      n_fail++;
      $display("FAIL rst_mid: busy=%b err=%b data=%h state=%0d, want 0 0 00000000 0",
               busy, error, read_data, dut.r_state);
    end
    test_table("rst_chk", chk);
  endtask

  task automatic test_wrap();
    req_t t[] = '{'{0, 1, F3_W, 32'h1000, 32'hCAFEF00D}, '{1, 0, F3_W, 32'h0, 32'h0}};
    test_table("wrap", t);
    n_tests++;
    if (read_data !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL wrap_kat: data=%h, want cafef00d", read_data);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_partial();
    test_faults();
    test_reset_mid_store();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder; serves the MEM stage's load/store requests (ADDRESS, WRITE_DATA, MEM_READ, MEM_WRITE, FUNC3) and returns READ_DATA.
- Owns the word-organised RAM, byte-lane steering, load sign/zero extension and misalignment checking.
- Drives BUSY so the pipeline stalls while an access is in flight.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth is 2**ADDR_WIDTH words of 32 bits.
- LATENCY, 2, cycles spent in ACCESS, integer >= 1.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- ADDRESS  input  32  byte address.
- WRITE_DATA  input  32  store data, right-aligned.
- MEM_READ  input  1  load request.
- MEM_WRITE  input  1  store request.
- FUNC3  input  3  access size/sign (RV32 load/store encoding).
- READ_DATA  output  32  extended load result.
- BUSY  output  1  stall request to pipeline.
- ERROR  output  1  one-cycle fault flag for a misaligned or illegal request.

Behaviour:
- One clock (CLK); reset RST is synchronous and active-high.
- States: IDLE, ACCESS, RESPOND.
- Reset: state=IDLE, counter=0, READ_DATA=0, ERROR=0, BUSY=0. RAM contents are not cleared.
- Reset mid-access aborts the access: a pending store is not committed.
- Request: MEM_READ xor MEM_WRITE high. The requester holds all request inputs stable while BUSY=1 and through the RESPOND cycle.
- BUSY = (IDLE and request) or ACCESS. It is combinational, so BUSY rises in the same cycle the request appears.
- IDLE, legal request:
  - Capture address, data, func3 and direction; counter=LATENCY-1; go to ACCESS.
- IDLE, faulting request:
  - Go directly to RESPOND.
  - No RAM access.
  - ERROR=1 and READ_DATA=0 during RESPOND.
- Fault conditions:
  - Both MEM_READ and MEM_WRITE high.
  - FUNC3 in {011,110,111}.
  - FUNC3 in {100,101} with MEM_WRITE.
  - Halfword with ADDRESS[0]=1.
  - Word with ADDRESS[1:0]!=00.
- ACCESS: decrement the counter. When it reaches 0, perform the RAM operation at the end of that cycle and go to RESPOND.
  - Store: byte enables from FUNC3 and ADDRESS[1:0].
    - SB writes byte lane ADDRESS[1:0] with WRITE_DATA[7:0].
    - SH writes lanes {1:0} or {3:2} with WRITE_DATA[15:0].
    - SW writes all four lanes.
    - Unselected lanes are preserved.
  - Load: read the word, select the lane, extend.
    - LB and LH sign-extend.
    - LBU and LHU zero-extend.
    - LW passes the word unchanged.
    - The result is registered into READ_DATA.
- RESPOND: BUSY=0. READ_DATA is valid for loads. Always go to IDLE next cycle.
  - A request seen in RESPOND is the already-served one and is ignored.
  - READ_DATA holds its value until the next load or fault completes. Stores leave READ_DATA unchanged.
- ERROR is high only in the RESPOND cycle of a faulting request.
- Latency:
  - Legal request: stall of LATENCY+1 cycles (BUSY high); data available in cycle LATENCY+1 after the request appears.
  - Fault: stall of 1 cycle.
- Address mapping: word index = ADDRESS[ADDR_WIDTH+1:2]. Higher bits are ignored, so addresses wrap modulo the RAM size.
- Back-to-back requests: a new request can start no earlier than the IDLE cycle after RESPOND. No pipelining of requests.
- Store followed by load to the same word returns the stored data (no bypass needed, since accesses are serialised).

Decomposition:
- Shared package (dmem_pkg):
  - FUNC3 constants: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
  - State encoding for IDLE/ACCESS/RESPOND.
  - Byte-enable width constant (4).
- Sub-module: dmem_lane_align. It is combinational and does three things:
  - Generates byte enables and replicated store data from FUNC3 and the low address bits.
  - Performs the load lane select with sign/zero extension.
  - Produces the misalignment/illegal flag.
- The top level holds the FSM, counter and RAM array.

Test Plan (LATENCY=2):
- SW 0xDEADBEEF @0x10, then LW @0x10:
  - Each request has BUSY high for exactly 3 cycles.
  - READ_DATA=0xDEADBEEF in the load's RESPOND cycle.
  - ERROR=0.
- Byte/half extension, with word @0x20=0x8001F07F:
  - LB @0x20 -> 0x0000007F.
  - LB @0x21 -> 0xFFFFFFF0.
  - LBU @0x21 -> 0x000000F0.
  - LH @0x22 -> 0xFFFF8001.
  - LHU @0x22 -> 0x00008001.
- Partial stores: word @0x30=0x11223344, then SB 0xAA @0x32 and SH 0xBEEF @0x30. LW @0x30 -> 0x11AABEEF.
- Faults:
  - LW @0x11, SH @0x21, FUNC3=011 load, and MEM_READ+MEM_WRITE together each give BUSY high for 1 cycle, ERROR=1 for 1 cycle and READ_DATA=0.
  - RAM is unchanged; check with a follow-up LW.
- Reset mid-store: issue SW 0x12345678 @0x40 (word previously 0), assert RST during ACCESS. Then:
  - State is IDLE and BUSY=0 the next cycle.
  - LW @0x40 -> 0x00000000.
- Wrap-around: SW 0xCAFEF00D @0x1000 (ADDR_WIDTH=10), then LW @0x0 -> 0xCAFEF00D.
